// File: rtl/bin_frame_sequencer.sv
// FFT output sequencer: tags samples with bin/frame, keeps bins 0..KEEP_BINS-1,
// and forwards them through a small first-word-fall-through FIFO.
module bin_frame_sequencer #(
  parameter int DATA_W     = 14,
  parameter int FFT_N      = 1024,
  parameter int KEEP_BINS  = 513,
  parameter int NUM_FRAMES = 89,
  parameter int FIFO_DEPTH = 8,
  localparam int BW = $clog2(FFT_N),
  localparam int FW = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              di_en,
  input  logic [DATA_W-1:0] di_re,
  input  logic [DATA_W-1:0] di_im,
  output logic              do_valid,
  input  logic              do_ready,
  output logic [DATA_W-1:0] do_re,
  output logic [DATA_W-1:0] do_im,
  output logic [BW-1:0]     do_bin,
  output logic [FW-1:0]     do_frame,
  output logic              frame_done,
  output logic              busy,
  output logic              done,
  output logic              overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = 2 * DATA_W + BW + FW;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [BW:0]   KEEP_L     = (BW+1)'(KEEP_BINS);
  localparam logic [BW-1:0] LAST_BIN   = BW'(FFT_N - 1);
  localparam logic [FW-1:0] LAST_FRAME = FW'(NUM_FRAMES - 1);
  localparam logic [AW:0]   FULL_CNT   = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]   ONE_CNT    = (AW+1)'(1);

  logic [1:0]    state;
  logic [BW-1:0] bin_cnt;
  logic [FW-1:0] frame_cnt;
  logic          frame_done_q;
  logic          overflow_q;

  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] head_ptr;
  logic [AW:0]   count;

  logic run;
  logic empty;
  logic full;
  logic push_req;
  logic pop;
  logic wr_en;
  logic drop;
  logic wrap;

  assign run      = (state == S_RUN);
  assign empty    = (count == '0);
  assign full     = (count == FULL_CNT);
  assign push_req = run && di_en && ({1'b0, bin_cnt} < KEEP_L);
  assign pop      = !empty && do_ready;
  assign wr_en    = push_req && (!full || pop);
  assign drop     = push_req && full && !pop;
  assign wrap     = run && di_en && (bin_cnt == LAST_BIN);

  // When empty the slot behind rd_ptr still holds the last popped entry,
  // so the outputs keep showing it without a separate holding register.
  assign head_ptr = empty ? rd_ptr - AW'(1) : rd_ptr;

  assign do_valid = !empty;
  assign {do_re, do_im, do_bin, do_frame} = mem[head_ptr];

  assign frame_done = frame_done_q;
  assign overflow   = overflow_q;
  assign busy       = (state == S_RUN) || (state == S_DRAIN);
  assign done       = (state == S_DONE);

  // FIFO storage, pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= {di_re, di_im, bin_cnt, frame_cnt};
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({wr_en, pop})
        2'b10:   count <= count + ONE_CNT;
        2'b01:   count <= count - ONE_CNT;
        default: count <= count;
      endcase
    end
  end

  // Run control: bin/frame counters, frame pulse, sticky overflow
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      bin_cnt      <= '0;
      frame_cnt    <= '0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      frame_done_q <= wrap;
      if (drop) begin
        overflow_q <= 1'b1;
      end
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state      <= S_RUN;
            bin_cnt    <= '0;
            frame_cnt  <= '0;
            overflow_q <= 1'b0;
          end
        end
        S_RUN: begin
          if (di_en) begin
            if (bin_cnt == LAST_BIN) begin
              bin_cnt <= '0;
              if (frame_cnt == LAST_FRAME) begin
                state <= S_DRAIN;
              end else begin
                frame_cnt <= frame_cnt + FW'(1);
              end
            end else begin
              bin_cnt <= bin_cnt + BW'(1);
            end
          end
        end
        S_DRAIN: begin
          if (empty || (count == ONE_CNT && pop)) begin
            state <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bin_frame_sequencer.sv
// Scoreboard bench for bin_frame_sequencer: directed frames, backpressure,
// full-FIFO push/pop, start handling and asynchronous reset mid-run.
module tb_bin_frame_sequencer;

  localparam int DW = 14;
  localparam int N  = 1024;
  localparam int K  = 513;
  localparam int NF = 6;
  localparam int D  = 8;
  localparam int BW = 10;
  localparam int FW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          di_en;
  logic [DW-1:0] di_re;
  logic [DW-1:0] di_im;
  logic          do_valid;
  logic          do_ready;
  logic [DW-1:0] do_re;
  logic [DW-1:0] do_im;
  logic [BW-1:0] do_bin;
  logic [FW-1:0] do_frame;
  logic          frame_done;
  logic          busy;
  logic          done;
  logic          overflow;

  typedef struct packed {
    logic [DW-1:0] re;
    logic [DW-1:0] im;
    logic [BW-1:0] bin;
    logic [FW-1:0] frm;
  } ent_t;

  ent_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   out_cnt = 0;
  int   fd_cnt = 0;
  int   fd_exp = 0;
  int   m_bin = 0;
  int   m_frame = 0;
  int   base;

  bin_frame_sequencer #(
    .DATA_W(DW), .FFT_N(N), .KEEP_BINS(K),
    .NUM_FRAMES(NF), .FIFO_DEPTH(D)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .di_en(di_en), .di_re(di_re), .di_im(di_im),
    .do_valid(do_valid), .do_ready(do_ready),
    .do_re(do_re), .do_im(do_im),
    .do_bin(do_bin), .do_frame(do_frame),
    .frame_done(frame_done), .busy(busy),
    .done(done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // One clock of input; kept=0 marks a sample the bench expects to be lost.
  task automatic put(input bit en, input bit kept);
    ent_t e;
    di_en = en;
    di_re = DW'(m_bin);
    di_im = DW'(-(m_bin + 7 * m_frame));
    if (en) begin
      if (m_bin < K && kept) begin
        e.re  = di_re;
        e.im  = di_im;
        e.bin = BW'(m_bin);
        e.frm = FW'(m_frame);
        exp_q.push_back(e);
      end
      if (m_bin == N - 1) begin
        fd_exp++;
        m_bin = 0;
        m_frame++;
      end else begin
        m_bin++;
      end
    end
    @(posedge clk);
    #1;
    di_en = 1'b0;
  endtask

  task automatic do_start();
    start   = 1'b1;
    m_bin   = 0;
    m_frame = 0;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic frame(input bit gap);
    for (int i = 0; i < N; i++) begin
      put(1'b1, 1'b1);
      if (gap && (i % 3 == 0)) put(1'b0, 1'b0);
    end
  endtask

  task automatic drain_wait();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain", exp_q.size(), 0);
  endtask

  // Monitor: pops the scoreboard on every accepted output, checks stalls.
  logic        pv;
  logic [40:0] prev;
  ent_t        me;
  always @(negedge clk) begin
    if (rst) begin
      pv = 1'b0;
    end else begin
      if (pv) chk("stall_hold", {do_re, do_im, do_bin, do_frame}, prev);
      if (do_valid && do_ready) begin
        out_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out actual=bin %0d frame %0d required=none",
                   do_bin, do_frame);
        end else begin
          me = exp_q.pop_front();
          chk("out", {do_re, do_im, do_bin, do_frame}, me);
        end
      end
      pv   = do_valid && !do_ready;
      prev = {do_re, do_im, do_bin, do_frame};
      if (frame_done) fd_cnt++;
    end
  end

  initial begin
    #1_000_000;
    checks++;
    errors++;
    $display("FAIL timeout actual=running required=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; start = 1'b0; di_en = 1'b0;
    di_re = '0; di_im = '0; do_ready = 1'b1;
    pv = 1'b0; prev = '0;
    repeat (2) @(negedge clk);
    chk("rst_valid", do_valid, 0);
    chk("rst_data", {do_re, do_im, do_bin, do_frame}, 0);
    chk("rst_flags", {frame_done, busy, done, overflow}, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // IDLE ignores di_en
    repeat (4) put(1'b1, 1'b0);
    @(negedge clk);
    chk("idle_valid", do_valid, 0);
    chk("idle_busy", busy, 0);

    // Run 1, frame 0: basic, data = bin index
    do_start();
    @(negedge clk);
    chk("run_busy", {busy, done}, 2'b10);
    frame(1'b0);
    @(negedge clk);
    chk("fd_pulse", frame_done, 1);
    @(negedge clk);
    chk("fd_single", frame_done, 0);
    drain_wait();
    chk("frame0_outs", out_cnt, K);
    chk("fd_count0", fd_cnt, fd_exp);

    // Frame 1: fill to full, then simultaneous push/pop
    do_ready = 1'b0;
    for (int i = 0; i < D; i++) put(1'b1, 1'b1);
    chk("full_valid", do_valid, 1);
    chk("full_head", do_bin, 0);
    do_ready = 1'b1;
    for (int i = D; i < N; i++) begin
      put(1'b1, 1'b1);
      if (i == K - 1) begin
        chk("full_occ", exp_q.size(), D);
        chk("full_no_ovf", overflow, 0);
      end
    end
    drain_wait();
    chk("f1_no_ovf", overflow, 0);

    // Frame 2 gapped, frame 3 with an ignored start
    frame(1'b1);
    for (int i = 0; i < 100; i++) put(1'b1, 1'b1);
    start = 1'b1;
    put(1'b1, 1'b1);
    start = 1'b0;
    for (int i = 101; i < N; i++) put(1'b1, 1'b1);
    chk("start_ignored", {busy, done}, 2'b10);
    frame(1'b0);
    frame(1'b0);
    @(negedge clk);
    chk("drain_state", {busy, done}, 2'b10);
    @(negedge clk);
    chk("done_state", {busy, done}, 2'b01);
    drain_wait();
    chk("run1_outs", out_cnt, NF * K);
    chk("fd_count1", fd_cnt, fd_exp);
    repeat (5) put(1'b1, 1'b0);
    @(negedge clk);
    chk("done_ignores", {do_valid, done}, 2'b01);

    // Run 2: backpressure overflow in frame 0
    base = out_cnt;
    do_ready = 1'b0;
    do_start();
    chk("restart_busy", {busy, done}, 2'b10);
    for (int i = 0; i < 20; i++) put(1'b1, (i < D));
    chk("ovf_set", overflow, 1);
    chk("bp_head", {do_valid, do_bin, do_frame}, {1'b1, 10'd0, 3'd0});
    do_ready = 1'b1;
    for (int i = 20; i < N; i++) put(1'b1, 1'b1);
    for (int f = 1; f < NF; f++) frame(1'b0);
    repeat (2) @(negedge clk);
    chk("ovf_sticky", {done, overflow}, 2'b11);
    drain_wait();
    chk("run2_outs", out_cnt - base, D + (K - 20) + (NF - 1) * K);

    // Run 3: start in DONE clears overflow, then reset mid-run
    do_start();
    @(negedge clk);
    chk("start_clr_ovf", {busy, overflow}, 2'b10);
    for (int f = 0; f < 5; f++) frame(1'b0);
    for (int i = 0; i < 300; i++) put(1'b1, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst", {do_valid, busy, done, overflow}, 0);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    base = out_cnt;
    repeat (10) put(1'b1, 1'b0);
    @(negedge clk);
    chk("post_rst_idle", {do_valid, busy}, 0);
    do_start();
    for (int i = 0; i < 6; i++) put(1'b1, 1'b1);
    drain_wait();
    chk("restart_outs", out_cnt - base, 6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
